// File: rtl/pcie_arb_pkg.sv
// Shared constants for pcie_axis_chan_arb: FSM state codes, counter widths and
// a saturating increment used by the drop counter.
package pcie_arb_pkg;

  localparam int DROP_CNT_W = 16;
  localparam int PKT_CNT_W  = 32;

  localparam logic [0:0] C_IDLE = 1'b0;
  localparam logic [0:0] C_BUSY = 1'b1;

  localparam logic [1:0] H_HDR  = 2'd0;
  localparam logic [1:0] H_FWD  = 2'd1;
  localparam logic [1:0] H_DROP = 2'd2;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// rr_arb: N-request round-robin picker. Returns the first requester found
// searching upward from last_grant+1 with wrap; valid=0 when nobody requests.
module rr_arb #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic [W-1:0] grant,
  output logic         valid
);

  // Walk the search order backwards so the nearest requester is written last.
  always_comb begin
    logic [W-1:0] idx;
    grant = last_grant;
    valid = 1'b0;
    idx   = '0;
    for (int k = N; k >= 1; k--) begin
      idx = W'((int'(last_grant) + k) % N);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie_axis_chan_arb.sv
// pcie_axis_chan_arb: XDMA stream fan-in (C2H, packet round-robin) and fan-out
// (H2C, steered by channel ID in beat 0). Packet counters need PCIE_AXIS_ARB_STATS_EN.
module pcie_axis_chan_arb
  import pcie_arb_pkg::*;
#(
  parameter int DATA_W   = 256,
  parameter int N_CHAN   = 4,
  parameter int CHAN_LSB = 0
) (
  input  logic                          clk,
  input  logic                          sys_reset,
  input  logic [N_CHAN-1:0]             c2h_in_tvalid,
  output logic [N_CHAN-1:0]             c2h_in_tready,
  input  logic [N_CHAN-1:0]             c2h_in_tlast,
  input  logic [N_CHAN*DATA_W-1:0]      c2h_in_tdata,
  input  logic [N_CHAN*DATA_W/8-1:0]    c2h_in_tkeep,
  output logic                          c2h_out_tvalid,
  input  logic                          c2h_out_tready,
  output logic                          c2h_out_tlast,
  output logic [DATA_W-1:0]             c2h_out_tdata,
  output logic [DATA_W/8-1:0]           c2h_out_tkeep,
  input  logic                          h2c_in_tvalid,
  output logic                          h2c_in_tready,
  input  logic                          h2c_in_tlast,
  input  logic [DATA_W-1:0]             h2c_in_tdata,
  input  logic [DATA_W/8-1:0]           h2c_in_tkeep,
  output logic [N_CHAN-1:0]             h2c_out_tvalid,
  input  logic [N_CHAN-1:0]             h2c_out_tready,
  output logic [N_CHAN-1:0]             h2c_out_tlast,
  output logic [DATA_W-1:0]             h2c_out_tdata,
  output logic [DATA_W/8-1:0]           h2c_out_tkeep,
  output logic [DROP_CNT_W-1:0]         h2c_drop_cnt,
  output logic [N_CHAN*PKT_CNT_W-1:0]   c2h_pkt_cnt,
  output logic [N_CHAN*PKT_CNT_W-1:0]   h2c_pkt_cnt
);

  localparam int CHAN_W = $clog2(N_CHAN);
  localparam int KEEP_W = DATA_W / 8;
  localparam logic [CHAN_W:0] N_CHAN_V = (CHAN_W+1)'(N_CHAN);

  genvar gi;

  // ---------------- C2H: packet-granular round robin ----------------
  logic [0:0]        c_state_reg;
  logic [CHAN_W-1:0] grant_reg, last_grant_reg, arb_grant;
  logic              arb_valid, c_busy, c2h_hs;

  rr_arb #(.N(N_CHAN), .W(CHAN_W)) u_rr_arb (
    .req        (c2h_in_tvalid),
    .last_grant (last_grant_reg),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  assign c_busy         = (c_state_reg == C_BUSY);
  assign c2h_out_tvalid = c_busy & c2h_in_tvalid[grant_reg];
  assign c2h_out_tlast  = c2h_in_tlast[grant_reg];
  assign c2h_out_tdata  = c2h_in_tdata[int'(grant_reg)*DATA_W +: DATA_W];
  assign c2h_out_tkeep  = c2h_in_tkeep[int'(grant_reg)*KEEP_W +: KEEP_W];
  assign c2h_hs         = c2h_out_tvalid & c2h_out_tready;

  for (gi = 0; gi < N_CHAN; gi++) begin : g_c2h_ready
    assign c2h_in_tready[gi] = c_busy && (grant_reg == CHAN_W'(gi)) && c2h_out_tready;
  end

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      c_state_reg    <= C_IDLE;
      grant_reg      <= '0;
      last_grant_reg <= CHAN_W'(N_CHAN - 1);
    end else begin
      case (c_state_reg)
        C_IDLE: begin
          if (arb_valid) begin
            grant_reg   <= arb_grant;
            c_state_reg <= C_BUSY;
          end
        end
        default: begin
          if (c2h_hs && c2h_out_tlast) begin
            last_grant_reg <= grant_reg;
            c_state_reg    <= C_IDLE;
          end
        end
      endcase
    end
  end

  // ---------------- H2C: steer by channel ID in beat 0 ----------------
  logic [1:0]            h_state_reg;
  logic [CHAN_W-1:0]     h_id_reg, hdr_id, route_id;
  logic                  hdr_ok, fwd_en, h2c_hs;
  logic [N_CHAN-1:0]     h2c_sel;
  logic [DROP_CNT_W-1:0] drop_cnt_reg;

  assign hdr_id   = h2c_in_tdata[CHAN_LSB +: CHAN_W];
  assign hdr_ok   = ({1'b0, hdr_id} < N_CHAN_V);
  assign route_id = (h_state_reg == H_FWD) ? h_id_reg : hdr_id;
  assign fwd_en   = (h_state_reg == H_FWD) || ((h_state_reg == H_HDR) && hdr_ok);

  for (gi = 0; gi < N_CHAN; gi++) begin : g_h2c_out
    assign h2c_sel[gi]        = fwd_en && (route_id == CHAN_W'(gi));
    assign h2c_out_tvalid[gi] = h2c_sel[gi] & h2c_in_tvalid;
    assign h2c_out_tlast[gi]  = h2c_sel[gi] & h2c_in_tlast;
  end

  // Header beat goes out untouched; sinks see the ID field too.
  assign h2c_out_tdata = h2c_in_tdata;
  assign h2c_out_tkeep = h2c_in_tkeep;
  assign h2c_drop_cnt  = drop_cnt_reg;
  assign h2c_hs        = h2c_in_tvalid & h2c_in_tready;

  always_comb begin
    case (h_state_reg)
      H_HDR:   h2c_in_tready = hdr_ok ? |(h2c_sel & h2c_out_tready) : 1'b1;
      H_FWD:   h2c_in_tready = |(h2c_sel & h2c_out_tready);
      H_DROP:  h2c_in_tready = 1'b1;
      default: h2c_in_tready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      h_state_reg  <= H_HDR;
      h_id_reg     <= '0;
      drop_cnt_reg <= '0;
    end else begin
      case (h_state_reg)
        H_HDR: begin
          if (h2c_hs) begin
            if (hdr_ok) begin
              if (!h2c_in_tlast) begin
                h_id_reg    <= hdr_id;
                h_state_reg <= H_FWD;
              end
            end else begin
              drop_cnt_reg <= sat_inc(drop_cnt_reg);
              if (!h2c_in_tlast) h_state_reg <= H_DROP;
            end
          end
        end
        H_FWD, H_DROP: begin
          if (h2c_hs && h2c_in_tlast) h_state_reg <= H_HDR;
        end
        default: h_state_reg <= H_HDR;
      endcase
    end
  end

  // ---------------- optional per-channel packet counters ----------------
`ifdef PCIE_AXIS_ARB_STATS_EN
  for (gi = 0; gi < N_CHAN; gi++) begin : g_stats
    logic [PKT_CNT_W-1:0] c2h_cnt_reg, h2c_cnt_reg;
    always_ff @(posedge clk or posedge sys_reset) begin
      if (sys_reset) begin
        c2h_cnt_reg <= '0;
        h2c_cnt_reg <= '0;
      end else begin
        if (c2h_in_tvalid[gi] && c2h_in_tready[gi] && c2h_in_tlast[gi])
          c2h_cnt_reg <= c2h_cnt_reg + 1'b1;
        if (h2c_out_tvalid[gi] && h2c_out_tready[gi] && h2c_out_tlast[gi])
          h2c_cnt_reg <= h2c_cnt_reg + 1'b1;
      end
    end
    assign c2h_pkt_cnt[gi*PKT_CNT_W +: PKT_CNT_W] = c2h_cnt_reg;
    assign h2c_pkt_cnt[gi*PKT_CNT_W +: PKT_CNT_W] = h2c_cnt_reg;
  end
`else
  assign c2h_pkt_cnt = '0;
  assign h2c_pkt_cnt = '0;
`endif

endmodule
